// File: rtl/reg_bank_param.sv
// reg_bank_param: parameterised register bank with a selectable write source,
// a registered two-port read and a sequential whole-bank clear sweep.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width; bank holds NREG = 2**ADDR_W registers
//   TOP_INIT reset/clear value of register NREG-1 (all others clear to 0)
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   wr_en      write request (dropped while busy or when clr_req is set)
//   wr_src     write source: 00 R0, 01 register[src_addr], 10 or2_in, 11 alu_in
//   src_addr   source register index for wr_src = 01
//   wr_addr    destination register index
//   or2_in     operand-register data
//   alu_in     ALU result
//   rd_en      read request; loads dataout_a/dataout_b, otherwise they hold
//   rd_addr_b  port-B read index
//   clr_req    start a sequential clear of the whole bank
//   dataout_a  registered R0
//   dataout_b  registered register[rd_addr_b]
//   wr_ack     one-cycle pulse confirming an accepted write
//   busy       clear sweep in progress
//
// Build option: define REG_BANK_BYPASS_EN to forward an accepted write to a
// same-cycle read of the same index.

module reg_bank_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned TOP_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_src,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] or2_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              clr_req,
  output logic [DATA_W-1:0] dataout_a,
  output logic [DATA_W-1:0] dataout_b,
  output logic              wr_ack,
  output logic              busy
);

  localparam int unsigned       NREG    = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] TopVal  = DATA_W'(TOP_INIT);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NREG - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   bank_q [NREG];
  logic [DATA_W-1:0]   bank_d [NREG];
  logic [DATA_W-1:0]   dout_a_q, dout_a_d;
  logic [DATA_W-1:0]   dout_b_q, dout_b_d;
  logic                ack_q;
  logic                wr_accept;
  logic [DATA_W-1:0]   wr_data;

  // Clear request wins over a simultaneous write.
  assign wr_accept = (state_q == StIdle) && wr_en && !clr_req;

  always_comb begin
    wr_data = '0;
    unique case (wr_src)
      2'b00:   wr_data = bank_q[0];
      2'b01:   wr_data = bank_q[src_addr];
      2'b10:   wr_data = or2_in;
      default: wr_data = alu_in;
    endcase
  end

  // Next-state for FSM, sweep index and bank contents.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          idx_d   = '0;
        end else if (wr_en) begin
          bank_d[wr_addr] = wr_data;
        end
      end
      StClear: begin
        bank_d[idx_q] = (idx_q == LastIdx) ? TopVal : '0;
        // Index wraps to 0 on the last slot, which is also where we leave.
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Read ports sample pre-edge bank contents; rd_en low holds the outputs.
  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (rd_en) begin
      dout_a_d = bank_q[0];
      dout_b_d = bank_q[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
      if (wr_accept && (wr_addr == rd_addr_b)) begin
        dout_b_d = wr_data;
      end
      if (wr_accept && (wr_addr == '0)) begin
        dout_a_d = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
      ack_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        bank_q[i] <= (i == NREG - 1) ? TopVal : '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      ack_q    <= wr_accept;
      bank_q   <= bank_d;
    end
  end

  assign dataout_a = dout_a_q;
  assign dataout_b = dout_b_q;
  assign wr_ack    = ack_q;
  assign busy      = (state_q == StClear);

endmodule
